usb_uart_tx_arbiter: RTL and testbench

- Shares the single USB-serial transmit byte stream (usb_uart uart_in_data/valid/ready) between NUM_REQ byte-stream requesters, e.g. loopback echo, status banner, debug dump.
- Round-robin grant, held for a whole message (until a byte tagged last), so messages never interleave.
- Timeout releases a requester that stalls mid-message.
- One-entry registered output stage drives the usb_uart input.

---
 rtl/usb_uart_tx_arbiter_pkg.sv | 12 +
 rtl/usb_uart_tx_arbiter_rr_pick.sv | 28 ++
 rtl/usb_uart_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_usb_uart_tx_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_uart_tx_arbiter_pkg.sv
// rtl/usb_uart_tx_arbiter_pkg.sv - shared constants and state type for the usb_uart transmit arbiter
package usb_uart_tx_arbiter_pkg;

    localparam int BYTE_W          = 8;
    localparam int TIMEOUT_1MS_48M = 48000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/usb_uart_tx_arbiter_rr_pick.sv
// rtl/usb_uart_tx_arbiter_rr_pick.sv - combinational rotate-priority picker
// Scans last_grant+1, +2, ... modulo N and returns the first set request.
module rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic             found,
    output logic [IDX_W-1:0] index
);

    always_comb begin
        int cand;
        cand  = 0;
        found = 1'b0;
        index = '0;
        // k runs to N so the last granted requester is considered last
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_grant) + k) % N;
            if (!found && req[cand]) begin
                found = 1'b1;
                index = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/usb_uart_tx_arbiter.sv
// rtl/usb_uart_tx_arbiter.sv - round-robin message arbiter feeding the usb_uart transmit byte stream
// Grant is held until a last-tagged byte or a starvation timeout; one registered output stage.
module usb_uart_tx_arbiter
    import usb_uart_tx_arbiter_pkg::*;
#(
    parameter  int NUM_REQ        = 2,
    parameter  int TIMEOUT_CYCLES = TIMEOUT_1MS_48M,
    localparam int REQ_W          = $clog2(NUM_REQ)
) (
    input  logic                        clk_48mhz,
    input  logic                        reset,
    input  logic [NUM_REQ*BYTE_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic [BYTE_W-1:0]           uart_in_data,
    output logic                        uart_in_valid,
    input  logic                        uart_in_ready,
    output logic [REQ_W-1:0]            grant_id,
    output logic                        busy,
    output logic                        timeout_pulse
);

    localparam int               CNT_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    arb_state_t        state;
    logic [REQ_W-1:0]  last_grant;
    logic [CNT_W-1:0]  starve_cnt;
    logic              can_load;
    logic              xfer;
    logic              starve;
    logic              found;
    logic [REQ_W-1:0]  pick;
    logic [BYTE_W-1:0] req_bytes [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bytes[i] = req_data[i*BYTE_W +: BYTE_W];
        end
    end

    assign can_load = !uart_in_valid || uart_in_ready;
    assign xfer     = (state == ST_LOCKED) && can_load &&  req_valid[grant_id];
    assign starve   = (state == ST_LOCKED) && can_load && !req_valid[grant_id];

    always_comb begin
        req_ready = '0;
        if (state == ST_LOCKED && can_load) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (REQ_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (found),
        .index      (pick)
    );

    // Output stage keeps draining regardless of arbiter state.
    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            uart_in_valid <= 1'b0;
            uart_in_data  <= '0;
        end else if (xfer) begin
            uart_in_valid <= 1'b1;
            uart_in_data  <= req_bytes[grant_id];
        end else if (uart_in_ready) begin
            uart_in_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk_48mhz or negedge reset) begin
        if (!reset) begin
            state         <= ST_IDLE;
            grant_id      <= '0;
            last_grant    <= REQ_W'(NUM_REQ - 1);
            starve_cnt    <= '0;
            busy          <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        grant_id   <= pick;
                        state      <= ST_LOCKED;
                        busy       <= 1'b1;
                        starve_cnt <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (xfer) begin
                        starve_cnt <= '0;
                        if (req_last[grant_id]) begin
                            last_grant <= grant_id;
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                        end
                    end else if (starve && TIMEOUT_EN) begin
                        // Only cycles the requester itself wastes count toward release
                        if (starve_cnt == CNT_LAST) begin
                            last_grant    <= grant_id;
                            state         <= ST_IDLE;
                            busy          <= 1'b0;
                            timeout_pulse <= 1'b1;
                            starve_cnt    <= '0;
                        end else begin
                            starve_cnt <= starve_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_usb_uart_tx_arbiter.sv
// tb/tb_usb_uart_tx_arbiter.sv - directed self-checking bench for usb_uart_tx_arbiter
module tb_usb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req_data;
    logic [1:0]  req_valid;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  uart_in_data;
    logic        uart_in_valid;
    logic        uart_in_ready;
    logic [0:0]  grant_id;
    logic        busy;
    logic        timeout_pulse;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [1:0] pend;
    logic       down_rdy;
    logic [7:0] out_q[$];
    int         out_cyc[$];
    int         pulse_n;
    int         pulse_cyc;
    int         acc_cyc[2];

    usb_uart_tx_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk_48mhz     (clk),
        .reset         (reset),
        .req_data      (req_data),
        .req_valid     (req_valid),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .uart_in_data  (uart_in_data),
        .uart_in_valid (uart_in_valid),
        .uart_in_ready (uart_in_ready),
        .grant_id      (grant_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One cycle of requester and sink model; all sampling happens 1ns after the falling edge.
    task automatic step();
        @(negedge clk);
        if (pend[0]) void'(q0.pop_front());
        if (pend[1]) void'(q1.pop_front());
        if (q0.size() > 0) begin
            req_valid[0] = 1'b1; req_data[7:0] = q0[0][7:0]; req_last[0] = q0[0][8];
        end else begin
            req_valid[0] = 1'b0; req_last[0] = 1'b0;
        end
        if (q1.size() > 0) begin
            req_valid[1] = 1'b1; req_data[15:8] = q1[0][7:0]; req_last[1] = q1[0][8];
        end else begin
            req_valid[1] = 1'b0; req_last[1] = 1'b0;
        end
        uart_in_ready = down_rdy;
        #1;
        pend = req_valid & req_ready;
        if (pend[0]) acc_cyc[0] = cyc + 1;
        if (pend[1]) acc_cyc[1] = cyc + 1;
        if (uart_in_valid && uart_in_ready) begin
            out_q.push_back(uart_in_data);
            out_cyc.push_back(cyc + 1);
        end
        if (timeout_pulse) begin
            pulse_n++;
            pulse_cyc = cyc;
        end
    endtask

    task automatic clear_model();
        q0.delete(); q1.delete(); pend = '0;
        req_valid = '0; req_last = '0; req_data = '0;
        down_rdy = 1'b1; uart_in_ready = 1'b1;
        out_q.delete(); out_cyc.delete(); pulse_n = 0; pulse_cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(q0.size() == 0 && q1.size() == 0 && !uart_in_valid && !busy) && n < max_cycles);
        checks++;
        if (!(q0.size() == 0 && q1.size() == 0 && !uart_in_valid && !busy)) begin
            errors++;
            $display("FAIL drain_bound: not idle after %0d cycles (q0=%0d q1=%0d valid=%b busy=%b)",
                     n, q0.size(), q1.size(), uart_in_valid, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #1;
        checks += 6;
        if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", uart_in_valid); end
        if (uart_in_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", uart_in_data); end
        if (req_ready !== 2'b00)    begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
        if (grant_id !== 1'b0)      begin errors++; $display("FAIL reset_grant: got %0d expected 0", grant_id); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL reset_pulse: got %b expected 0", timeout_pulse); end
    endtask

    task automatic test_single();
        do_reset();
        q0 = '{9'h041, 9'h042, 9'h143};
        step();
        checks += 2;
        if (busy !== 1'b0)       begin errors++; $display("FAIL single_arb_busy: got %b expected 0", busy); end
        if (req_ready !== 2'b00) begin errors++; $display("FAIL single_arb_ready: got %b expected 00", req_ready); end
        step();
        checks += 4;
        if (grant_id !== 1'b0)      begin errors++; $display("FAIL single_grant: got %0d expected 0", grant_id); end
        if (busy !== 1'b1)          begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
        if (req_ready !== 2'b01)    begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
        if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", uart_in_valid); end
        step();
        checks += 2;
        if (uart_in_valid !== 1'b1) begin errors++; $display("FAIL single_valid1: got %b expected 1", uart_in_valid); end
        if (uart_in_data !== 8'h41) begin errors++; $display("FAIL single_byte1: got %h expected 41", uart_in_data); end
        step();
        checks++;
        if (uart_in_data !== 8'h42) begin errors++; $display("FAIL single_byte2: got %h expected 42", uart_in_data); end
        step();
        checks += 3;
        if (uart_in_data !== 8'h43) begin errors++; $display("FAIL single_byte3: got %h expected 43", uart_in_data); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL single_busy_fall: got %b expected 0", busy); end
        if (req_ready !== 2'b00)    begin errors++; $display("FAIL single_ready_fall: got %b expected 00", req_ready); end
        step();
        checks++;
        if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", uart_in_valid); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_a [4] = '{8'h10, 8'h11, 8'h20, 8'h21};
        logic [7:0] exp_c [4] = '{8'h24, 8'h25, 8'h14, 8'h15};
        int         gap_a [3] = '{1, 2, 1};
        do_reset();
        q0 = '{9'h010, 9'h111};
        q1 = '{9'h020, 9'h121};
        run_until_idle(40);
        checks++;
        if (out_q.size() != 4) begin
            errors++; $display("FAIL b2b_count: got %0d bytes expected 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[i] !== exp_a[i]) begin
                    errors++; $display("FAIL b2b_order[%0d]: got %h expected %h", i, out_q[i], exp_a[i]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_cyc[i+1] - out_cyc[i] != gap_a[i]) begin
                    errors++; $display("FAIL b2b_gap[%0d]: got %0d cycles expected %0d", i, out_cyc[i+1] - out_cyc[i], gap_a[i]);
                end
            end
        end
        q0 = '{9'h012, 9'h113};
        run_until_idle(20);
        out_q.delete(); out_cyc.delete();
        q0 = '{9'h014, 9'h115};
        q1 = '{9'h024, 9'h125};
        run_until_idle(40);
        checks++;
        if (out_q.size() != 4) begin
            errors++; $display("FAIL rotate_count: got %0d bytes expected 4", out_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (out_q[i] !== exp_c[i]) begin
                    errors++; $display("FAIL rotate_order[%0d]: got %h expected %h", i, out_q[i], exp_c[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [7:0] exp_s [3] = '{8'h33, 8'h34, 8'h35};
        do_reset();
        q0 = '{9'h033};
        step();
        step();
        down_rdy = 1'b0;
        for (int i = 0; i < 11; i++) begin
            step();
            checks += 4;
            if (uart_in_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, uart_in_valid); end
            if (uart_in_data !== 8'h33) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 33", i, uart_in_data); end
            if (req_ready !== 2'b00)    begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 00", i, req_ready); end
            if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL stall_pulse[%0d]: got %b expected 0", i, timeout_pulse); end
        end
        q0 = '{9'h034, 9'h135};
        down_rdy = 1'b1;
        run_until_idle(30);
        checks++;
        if (pulse_n != 0) begin errors++; $display("FAIL stall_no_timeout: got %0d pulses expected 0", pulse_n); end
        checks++;
        if (out_q.size() != 3) begin
            errors++; $display("FAIL stall_count: got %0d bytes expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_q[i] !== exp_s[i]) begin
                    errors++; $display("FAIL stall_order[%0d]: got %h expected %h", i, out_q[i], exp_s[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        logic [7:0] exp_t [3] = '{8'h55, 8'h20, 8'h21};
        do_reset();
        q0 = '{9'h055};
        q1 = '{9'h020, 9'h121};
        run_until_idle(60);
        checks += 3;
        if (pulse_n != 1) begin errors++; $display("FAIL timeout_pulses: got %0d expected 1", pulse_n); end
        if (pulse_cyc - acc_cyc[0] != 8) begin
            errors++; $display("FAIL timeout_delay: got %0d cycles expected 8", pulse_cyc - acc_cyc[0]);
        end
        if (grant_id !== 1'b1) begin errors++; $display("FAIL timeout_next_grant: got %0d expected 1", grant_id); end
        checks++;
        if (out_q.size() != 3) begin
            errors++; $display("FAIL timeout_count: got %0d bytes expected 3", out_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (out_q[i] !== exp_t[i]) begin
                    errors++; $display("FAIL timeout_order[%0d]: got %h expected %h", i, out_q[i], exp_t[i]);
                end
            end
        end
    endtask

    task automatic test_last_at_limit();
        do_reset();
        q0 = '{9'h061};
        repeat (9) step();
        q0.push_back(9'h162);
        step();
        checks += 2;
        if (req_ready !== 2'b01)    begin errors++; $display("FAIL limit_still_locked: got %b expected 01", req_ready); end
        if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL limit_early_pulse: got %b expected 0", timeout_pulse); end
        step();
        checks += 2;
        if (busy !== 1'b0)          begin errors++; $display("FAIL limit_release: got %b expected 0", busy); end
        if (timeout_pulse !== 1'b0) begin errors++; $display("FAIL limit_pulse: got %b expected 0", timeout_pulse); end
        run_until_idle(20);
        checks += 2;
        if (pulse_n != 0) begin errors++; $display("FAIL limit_pulses: got %0d expected 0", pulse_n); end
        if (out_q.size() != 2 || out_q[0] !== 8'h61 || out_q[out_q.size()-1] !== 8'h62) begin
            errors++; $display("FAIL limit_bytes: got %0d bytes expected 61,62", out_q.size());
        end
    endtask

    task automatic test_reset_locked();
        do_reset();
        q0 = '{9'h1A0};
        run_until_idle(20);
        down_rdy = 1'b0;
        q1 = '{9'h0B0, 9'h1B1};
        repeat (4) step();
        checks += 2;
        if (busy !== 1'b1 || uart_in_valid !== 1'b1) begin
            errors++; $display("FAIL rl_pre_state: got busy=%b valid=%b expected 1,1", busy, uart_in_valid);
        end
        if (uart_in_data !== 8'hB0) begin errors++; $display("FAIL rl_pre_data: got %h expected b0", uart_in_data); end
        reset = 1'b0;
        #1;
        checks += 5;
        if (uart_in_valid !== 1'b0) begin errors++; $display("FAIL rl_valid: got %b expected 0", uart_in_valid); end
        if (uart_in_data !== 8'h00) begin errors++; $display("FAIL rl_data: got %h expected 00", uart_in_data); end
        if (busy !== 1'b0)          begin errors++; $display("FAIL rl_busy: got %b expected 0", busy); end
        if (req_ready !== 2'b00)    begin errors++; $display("FAIL rl_ready: got %b expected 00", req_ready); end
        if (grant_id !== 1'b0)      begin errors++; $display("FAIL rl_grant: got %0d expected 0", grant_id); end
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        q0 = '{9'h1C0};
        q1 = '{9'h1D0};
        run_until_idle(20);
        checks++;
        if (out_q.size() != 2 || out_q[0] !== 8'hC0 || out_q[out_q.size()-1] !== 8'hD0) begin
            errors++; $display("FAIL rl_first_winner: got %0d bytes first=%h expected c0 then d0",
                               out_q.size(), (out_q.size() > 0) ? out_q[0] : 8'h00);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_timeout();
        test_last_at_limit();
        test_reset_locked();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
